// File: rtl/adsb_pkg.sv
// adsb_pkg: shared ADS-B constants, transmit FSM state type and preamble chip helper
package adsb_pkg;
    localparam int ADSB_MESSAGE_WIDTH = 112;
    localparam int ADSB_PREAMBLE_CHIPS = 16;
    localparam int ADSB_FRAME_CHIPS = 240;
    localparam logic [15:0] ADSB_TX_MAGIC = 16'hAD5B;
    localparam int ADSB_TX_FRAME_WORDS = 5;
    typedef enum logic [2:0] {COLLECT, DISCARD, PREAMBLE, DATA, GAP} adsb_tx_state_t;
    function automatic logic adsb_preamble_chip(input logic [7:0] h);
        return h == 8'd0 || h == 8'd2 || h == 8'd7 || h == 8'd9;
    endfunction
endpackage

// File: rtl/adsb_sample_strobe.sv
// adsb_sample_strobe: free-running CLOCKS_PER_SAMPLE divider producing the DAC sample strobe
//   clk      in  clock
//   rst      in  synchronous active-high reset
//   strobe_o out one-cycle strobe when the divider count reaches CLOCKS_PER_SAMPLE-1
module adsb_sample_strobe #(
    parameter int CLOCKS_PER_SAMPLE = 4
) (
    input  logic clk,
    input  logic rst,
    output logic strobe_o
);
    localparam int CW = CLOCKS_PER_SAMPLE > 1 ? $clog2(CLOCKS_PER_SAMPLE) : 1;
    logic [CW-1:0] cnt_q;
    logic en_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            en_q <= 1'b0;
        end else begin
            cnt_q <= cnt_q == CW'(CLOCKS_PER_SAMPLE - 1) ? '0 : cnt_q + CW'(1);
            en_q <= 1'b1;
        end
    end
    // en_q keeps the strobe low while reset is held, even for a divide-by-1
    assign strobe_o = en_q && cnt_q == CW'(CLOCKS_PER_SAMPLE - 1);
endmodule

// File: rtl/adsb_modulator.sv
// adsb_modulator: AXI-stream ADS-B frame in, PPM baseband IQ samples out on a DAC strobe
//   Data_clk/Data_rst   clock, synchronous active-high reset
//   S_axis_*            5-word frame input (magic+amplitude, then 112-bit message)
//   Dac_valid           free-running sample strobe
//   Dac_data_i/_q       signed I/Q samples (Q always 0), change only on Dac_valid
//   Busy                high from first preamble sample through end of the gap
//   Error_length/header one-cycle pulses for malformed / bad-magic frames
module adsb_modulator
    import adsb_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int IQ_WIDTH = 16,
    parameter int CLOCKS_PER_SAMPLE = 4,
    parameter int SAMPLES_PER_HALF_US = 2,
    parameter int GAP_HALF_US = 8
) (
    input  logic                      Data_clk,
    input  logic                      Data_rst,
    output logic                      S_axis_ready,
    input  logic                      S_axis_valid,
    input  logic [AXI_DATA_WIDTH-1:0] S_axis_data,
    input  logic                      S_axis_last,
    output logic                      Dac_valid,
    output logic [IQ_WIDTH-1:0]       Dac_data_i,
    output logic [IQ_WIDTH-1:0]       Dac_data_q,
    output logic                      Busy,
    output logic                      Error_length,
    output logic                      Error_header
);
    localparam int SW = SAMPLES_PER_HALF_US > 1 ? $clog2(SAMPLES_PER_HALF_US) : 1;
    localparam logic [2:0] LAST_WORD = 3'(ADSB_TX_FRAME_WORDS - 1);
    logic dv;
    adsb_sample_strobe #(.CLOCKS_PER_SAMPLE(CLOCKS_PER_SAMPLE)) u_strobe (
        .clk(Data_clk),
        .rst(Data_rst),
        .strobe_o(dv)
    );
    adsb_tx_state_t state_q, state_d;
    logic [2:0] wcnt_q, wcnt_d;
    logic [ADSB_MESSAGE_WIDTH-1:0] msg_q, msg_d;
    logic [IQ_WIDTH-2:0] amp_q, amp_d;
    logic magic_q, magic_d;
    logic [7:0] h_q, h_d;
    logic [SW-1:0] s_q, s_d;
    logic started_q, started_d, ready_q, ready_d;
    logic err_len_q, err_len_d, err_hdr_q, err_hdr_d;
    logic [IQ_WIDTH-1:0] hold_q, cur_i;
    logic acc, tx, tx_d, chip_end, chip_high;
    assign acc = ready_q && S_axis_valid;
    assign tx = state_q inside {PREAMBLE, DATA, GAP};
    assign tx_d = state_d inside {PREAMBLE, DATA, GAP};
    assign chip_end = dv && tx && s_q == SW'(SAMPLES_PER_HALF_US - 1);
    // msg_q[MSB] is always the bit currently on air: even chip high for '1', odd chip high for '0'
    assign chip_high = state_q == PREAMBLE ? adsb_preamble_chip(h_q)
                     : state_q == DATA && (h_q[0] ^ msg_q[ADSB_MESSAGE_WIDTH-1]);
    assign cur_i = chip_high ? {1'b0, amp_q} : '0;
    always_comb begin
        state_d = state_q;
        wcnt_d = wcnt_q;
        msg_d = msg_q;
        amp_d = amp_q;
        magic_d = magic_q;
        h_d = h_q;
        s_d = s_q;
        err_len_d = 1'b0;
        err_hdr_d = 1'b0;
        if (state_q == COLLECT) begin
            if (acc) begin
                wcnt_d = wcnt_q + 3'd1;
                if (wcnt_q == 3'd0) begin
                    amp_d = S_axis_data[IQ_WIDTH-2:0];
                    magic_d = S_axis_data[31:16] == ADSB_TX_MAGIC;
                end else if (wcnt_q == LAST_WORD) begin
                    msg_d = {msg_q[95:0], S_axis_data[31:16]};
                end else begin
                    msg_d = {msg_q[79:0], S_axis_data};
                end
                if (wcnt_q == LAST_WORD || S_axis_last) begin
                    wcnt_d = 3'd0;
                    err_len_d = !(wcnt_q == LAST_WORD && S_axis_last);
                    err_hdr_d = wcnt_q == LAST_WORD && S_axis_last && !magic_q;
                    state_d = wcnt_q != LAST_WORD ? COLLECT
                            : !S_axis_last ? DISCARD
                            : magic_q ? PREAMBLE : COLLECT;
                end
            end
        end else if (state_q == DISCARD) begin
            state_d = acc && S_axis_last ? COLLECT : DISCARD;
        end else if (dv) begin
            s_d = chip_end ? '0 : s_q + SW'(1);
            if (chip_end) begin
                h_d = h_q + 8'd1;
                if (state_q == DATA && h_q[0])
                    msg_d = msg_q << 1;
                if (state_q == PREAMBLE && h_q == 8'(ADSB_PREAMBLE_CHIPS - 1))
                    state_d = DATA;
                if (state_q == DATA && h_q == 8'(ADSB_FRAME_CHIPS - 1)) begin
                    state_d = GAP;
                    h_d = 8'd0;
                end
                if (state_q == GAP && h_q == 8'(GAP_HALF_US - 1)) begin
                    state_d = COLLECT;
                    h_d = 8'd0;
                end
            end
        end
    end
    // started_q makes Busy rise on the first transmitted strobe rather than at frame acceptance
    assign started_d = tx_d && (started_q || (dv && tx));
    assign ready_d = state_d == COLLECT || state_d == DISCARD;
    always_ff @(posedge Data_clk) begin
        if (Data_rst) begin
            state_q <= COLLECT;
            wcnt_q <= 3'd0;
            msg_q <= '0;
            amp_q <= '0;
            magic_q <= 1'b0;
            h_q <= 8'd0;
            s_q <= '0;
            started_q <= 1'b0;
            ready_q <= 1'b0;
            err_len_q <= 1'b0;
            err_hdr_q <= 1'b0;
            hold_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q <= wcnt_d;
            msg_q <= msg_d;
            amp_q <= amp_d;
            magic_q <= magic_d;
            h_q <= h_d;
            s_q <= s_d;
            started_q <= started_d;
            ready_q <= ready_d;
            err_len_q <= err_len_d;
            err_hdr_q <= err_hdr_d;
            hold_q <= dv ? cur_i : hold_q;
        end
    end
    // The sample is presented in the strobe cycle itself and held until the next strobe
    assign Dac_valid = dv;
    assign Dac_data_i = dv ? cur_i : hold_q;
    assign Dac_data_q = '0;
    assign Busy = tx && (started_q || dv);
    assign S_axis_ready = ready_q;
    assign Error_length = err_len_q;
    assign Error_header = err_hdr_q;
endmodule

// File: tb/tb_adsb_modulator.sv
// tb_adsb_modulator: directed self-checking bench for adsb_modulator
module tb_adsb_modulator;
    logic clk = 1'b0;
    logic rst, ready, valid, last, dv, busy, el, eh;
    logic [31:0] data;
    logic [15:0] di, dq;
    int checks = 0, failures = 0;
    int cyc = 0, acc_cyc = 0, rise_cyc = 0;
    int busy_cyc = 0, len_hi = 0, len_p = 0, hdr_hi = 0, hdr_p = 0, rdy_busy = 0;
    int q_bad = 0, upd_bad = 0, idle_nz = 0, busy_mis = 0;
    logic busy_prev = 1'b0, len_prev = 1'b0, hdr_prev = 1'b0;
    logic [15:0] dac_prev = '0;
    logic [15:0] samp[$];
    localparam logic [111:0] M1 = 112'h8D4840D6202CC371C32CE0576098;
    localparam logic [111:0] M3A = 112'h8D40621D58C382D690C8AC2863A7;
    localparam logic [111:0] M3B = 112'h5D3C6614A5F0E2B7C9013D886E21;

    adsb_modulator dut (
        .Data_clk(clk), .Data_rst(rst), .S_axis_ready(ready), .S_axis_valid(valid),
        .S_axis_data(data), .S_axis_last(last), .Dac_valid(dv), .Dac_data_i(di),
        .Dac_data_q(dq), .Busy(busy), .Error_length(el), .Error_header(eh)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (dv && busy) samp.push_back(di);
        if (dv && dq !== 16'h0) q_bad++;
        if (!rst && !dv && di !== dac_prev) upd_bad++;
        if (!busy && dv && di !== 16'h0) idle_nz++;
        if (busy) busy_cyc++;
        if (busy && !busy_prev) begin
            rise_cyc = cyc;
            if (!dv) busy_mis++;
        end
        if (busy && ready) rdy_busy++;
        if (ready && valid && last) acc_cyc = cyc;
        if (el) len_hi++;
        if (el && !len_prev) len_p++;
        if (eh) hdr_hi++;
        if (eh && !hdr_prev) hdr_p++;
        busy_prev = busy;
        len_prev = el;
        hdr_prev = eh;
        dac_prev = di;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_sample(input logic [111:0] msg, input logic [15:0] amp, input int j);
        int h, k;
        logic hi;
        h = j / 2;
        if (j >= 480) return 16'h0;
        if (h < 16) hi = (h == 0 || h == 2 || h == 7 || h == 9);
        else begin
            k = (h - 16) / 2;
            hi = msg[111-k] ? (h % 2 == 0) : (h % 2 == 1);
        end
        return hi ? {1'b0, amp[14:0]} : 16'h0;
    endfunction

    task automatic cmp_frame(input string tag, input int off, input logic [111:0] msg, input logic [15:0] amp);
        int bad = 0;
        for (int j = 0; j < 496; j++)
            if (off + j >= samp.size() || samp[off+j] !== exp_sample(msg, amp, j)) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        valid = 1'b1;
        data = d;
        last = l;
        while (!ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("ready_timeout", 32'(n), 0);
        @(posedge clk);
        #1;
        valid = 1'b0;
        last = 1'b0;
    endtask

    task automatic send_frame(input logic [111:0] msg, input logic [15:0] amp, input logic [15:0] magic);
        send_word({magic, amp}, 1'b0);
        send_word(msg[111:80], 1'b0);
        send_word(msg[79:48], 1'b0);
        send_word(msg[47:16], 1'b0);
        send_word({msg[15:0], 16'h5A5A}, 1'b1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_busy_rise"}, 32'(busy), 1);
        n = 0;
        while (busy && n < 2500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_busy_fall"}, 32'(busy), 0);
        #1;
    endtask

    task automatic clr();
        samp.delete();
        busy_cyc = 0;
        len_hi = 0;
        len_p = 0;
        hdr_hi = 0;
        hdr_p = 0;
        rdy_busy = 0;
    endtask

    initial begin
        rst = 1'b1;
        valid = 1'b0;
        last = 1'b0;
        data = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_valid", 32'(dv), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_dac_i", 32'(di), 0);
        chk("rst_errs", {30'h0, el, eh}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_release", 32'(ready), 1);
        chk("no_early_strobe", 32'(dv), 0);
        repeat (2) @(negedge clk);
        chk("first_strobe", 32'(dv), 1);

        @(posedge clk);
        #1;
        clr();
        send_frame(M1, 16'h1000, 16'hAD5B);
        wait_done("t1");
        chk("t1_count", 32'(samp.size()), 496);
        cmp_frame("t1_frame", 0, M1, 16'h1000);
        chk("t1_s0", 32'(samp[0]), 32'h1000);
        chk("t1_s2", 32'(samp[2]), 32'h0);
        chk("t1_s32", 32'(samp[32]), 32'h1000);
        chk("t1_s34", 32'(samp[34]), 32'h0);
        chk("t1_busy_cycles", 32'(busy_cyc), 1981);
        chk("t1_latency_ok", 32'(rise_cyc - acc_cyc >= 1 && rise_cyc - acc_cyc <= 4), 1);
        chk("t1_errs", 32'(len_p + hdr_p), 0);

        clr();
        send_frame(112'h0, 16'h07FF, 16'hAD5B);
        wait_done("t2");
        chk("t2_count", 32'(samp.size()), 496);
        cmp_frame("t2_frame", 0, 112'h0, 16'h07FF);
        chk("t2_s4", 32'(samp[4]), 32'h07FF);
        chk("t2_s6", 32'(samp[6]), 32'h0);
        chk("t2_s32", 32'(samp[32]), 32'h0);
        chk("t2_s34", 32'(samp[34]), 32'h07FF);

        clr();
        send_frame(M3A, 16'h0400, 16'hAD5B);
        send_frame(M3B, 16'h3ABC, 16'hAD5B);
        wait_done("t3");
        chk("t3_count", 32'(samp.size()), 992);
        cmp_frame("t3_frame_a", 0, M3A, 16'h0400);
        cmp_frame("t3_frame_b", 496, M3B, 16'h3ABC);
        chk("t3_ready_while_busy", 32'(rdy_busy), 0);

        clr();
        send_word({16'hAD5B, 16'h1000}, 1'b0);
        send_word(M1[111:80], 1'b0);
        send_word(M1[79:48], 1'b1);
        repeat (20) @(negedge clk);
        chk("t4_short_len_pulses", 32'(len_p), 1);
        chk("t4_short_len_width", 32'(len_hi), 1);
        chk("t4_short_no_tx", 32'(busy_cyc), 0);
        @(posedge clk);
        #1;
        clr();
        send_word({16'hAD5B, 16'h1000}, 1'b0);
        send_word(M1[111:80], 1'b0);
        send_word(M1[79:48], 1'b0);
        send_word(M1[47:16], 1'b0);
        send_word({M1[15:0], 16'h0}, 1'b0);
        send_word(32'hAD5B0123, 1'b0);
        send_word(32'h11111111, 1'b1);
        repeat (20) @(negedge clk);
        chk("t4_long_len_pulses", 32'(len_p), 1);
        chk("t4_long_no_tx", 32'(busy_cyc), 0);
        send_frame(M1, 16'h1000, 16'hAD5B);
        wait_done("t4");
        chk("t4_count", 32'(samp.size()), 496);
        cmp_frame("t4_frame", 0, M1, 16'h1000);
        chk("t4_hdr", 32'(hdr_p), 0);

        clr();
        send_frame(M1, 16'h1000, 16'hAD5C);
        repeat (20) @(negedge clk);
        chk("t5_hdr_pulses", 32'(hdr_p), 1);
        chk("t5_hdr_width", 32'(hdr_hi), 1);
        chk("t5_len", 32'(len_p), 0);
        chk("t5_no_busy", 32'(busy_cyc), 0);
        send_frame(M3B, 16'h0123, 16'hAD5B);
        wait_done("t5");
        chk("t5_count", 32'(samp.size()), 496);
        cmp_frame("t5_frame", 0, M3B, 16'h0123);

        @(posedge clk);
        #1;
        clr();
        send_frame(M1, 16'h1000, 16'hAD5B);
        begin
            int n = 0;
            while (samp.size() < 5 && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        chk("t6_reached_s5", 32'(samp.size()), 5);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_ready", 32'(ready), 0);
        chk("t6_valid", 32'(dv), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_dac_i", 32'(di), 0);
        chk("t6_errs", {30'h0, el, eh}, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("t6_ready_at_release", 32'(ready), 0);
        @(negedge clk);
        chk("t6_ready_after_release", 32'(ready), 1);
        chk("t6_no_more_samples", 32'(samp.size()), 5);
        @(posedge clk);
        #1;
        clr();
        send_frame(M3A, 16'h2000, 16'hAD5B);
        wait_done("t6");
        chk("t6_count", 32'(samp.size()), 496);
        cmp_frame("t6_frame", 0, M3A, 16'h2000);

        chk("q_always_zero", 32'(q_bad), 0);
        chk("dac_changes_only_on_strobe", 32'(upd_bad), 0);
        chk("idle_output_zero", 32'(idle_nz), 0);
        chk("busy_rises_on_strobe", 32'(busy_mis), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
